muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, beside the single-cycle ALU. It consumes the decoder's M-extension operation selector and the two register operands, and delivers a 32-bit result after a fixed multi-cycle latency. While it works, it holds the pipeline through `busy_o`. It uses shift-add multiplication and restoring division, sharing one 2·XLEN working register.

---
 rtl/definitions_pkg.sv | 26 ++
 rtl/muldiv_unit.sv | 132 +++++++++++++
 tb/tb_muldiv_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/definitions_pkg.sv
// Shared decode types for the execute stage: RV32M operation selector encoded as funct3.
package definitions_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_e;

  // Kept outside the enum body so the 'x value cannot alias a legal encoding.
  localparam muldiv_e MD_XXX = muldiv_e'(3'bxxx);

  function automatic logic op_signed_a(input muldiv_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_signed_b(input muldiv_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide sharing
// one 2*XLEN working register, fixed XLEN-cycle latency, special cases in one cycle.
module muldiv_unit
  import definitions_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  muldiv_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] work;
  logic [XLEN-1:0]   opnd;
  muldiv_e           op_q;
  logic              neg_res;
  logic              neg_rem;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, ovf, special;
  logic [XLEN-1:0]   special_res;

  logic [XLEN:0]     sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic              ge;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, work_nxt, prod;
  logic [XLEN-1:0]   quo, remd, final_res;

  assign accept = start_i && !flush_i && (state == S_IDLE || state == S_DONE);

  always_comb begin
    a_neg    = op_signed_a(op_i) && a_i[XLEN-1];
    b_neg    = op_signed_b(op_i) && b_i[XLEN-1];
    a_mag    = a_neg ? -a_i : a_i;
    b_mag    = b_neg ? -b_i : b_i;
    div_zero = op_i[2] && (b_i == '0);
    ovf      = (op_i == MD_DIV || op_i == MD_REM) &&
               (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
    special  = div_zero || ovf;
    // op_i[1] distinguishes REM/REMU from DIV/DIVU within the divide group
    if (div_zero) special_res = op_i[1] ? a_i : '1;
    else          special_res = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  always_comb begin
    sum     = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, opnd} : '0);
    mul_nxt = {sum, work[XLEN-1:1]};
    // The partial remainder stays below the divisor, so the shifted value fits in
    // XLEN+1 bits and the top bit of the difference is the borrow.
    rem_sh  = work[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, opnd};
    ge      = !diff[XLEN];
    div_nxt = {ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0], work[XLEN-2:0], ge};
    work_nxt = op_q[2] ? div_nxt : mul_nxt;

    prod = neg_res ? -work_nxt : work_nxt;
    quo  = neg_res ? -work_nxt[XLEN-1:0] : work_nxt[XLEN-1:0];
    remd = neg_rem ? -work_nxt[2*XLEN-1:XLEN] : work_nxt[2*XLEN-1:XLEN];
    case (op_q)
      MD_MUL:                       final_res = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              final_res = quo;
      default:                      final_res = remd;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      work     <= '0;
      opnd     <= '0;
      op_q     <= MD_MUL;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= op_i;
      opnd    <= op_i[2] ? b_mag : a_mag;
      work    <= {{XLEN{1'b0}}, op_i[2] ? a_mag : b_mag};
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      cnt     <= '0;
      if (special) begin
        result_q <= special_res;
        state    <= S_DONE;
      end else begin
        state    <= S_BUSY;
      end
    end else if (flush_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_BUSY: begin
          work <= work_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(XLEN - 1)) begin
            result_q <= final_res;
            state    <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_IDLE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = (state == S_BUSY);
  assign done_o   = (state == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected result and done cycle,
// a negedge monitor pops and compares whenever done_o is presented.
module tb_muldiv_unit;
  import definitions_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, flush_i;
  muldiv_e     op_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .flush_i(flush_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit is_special(input muldiv_e op, input logic [31:0] a, input logic [31:0] b);
    if (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU} && b == 0) return 1;
    if (op inside {MD_DIV, MD_REM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 0;
  endfunction

  // Reference model: plain 64-bit / 32-bit arithmetic straight from the RV32M rules.
  function automatic logic [31:0] model(input muldiv_e op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb2, ua, ub, p;
    logic [63:0] up;
    int          ia, ib;
    sa = longint'($signed(a)); sb2 = longint'($signed(b));
    ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
    ia = a; ib = b;
    case (op)
      MD_MUL:    begin p = ua * ub;  return p[31:0];  end
      MD_MULH:   begin p = sa * sb2; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub;  return p[63:32]; end
      MD_MULHU:  begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      MD_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done_o=1 result %h expected no done (t=%0t)", result_o, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result_o, e.res);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive a start just after a negedge; accept happens on the following posedge.
  task automatic issue(input muldiv_e op, input logic [31:0] a, input logic [31:0] b, input bit expect_done);
    exp_t e;
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    if (expect_done) begin
      e.res = model(op, a, b);
      e.cyc = cyc + 1 + (is_special(op, a, b) ? 0 : 32);
      sb.push_back(e);
      last_res = e.res;
    end
  endtask

  task automatic wait_done(input bit hold, output int busy_n);
    bit seen;
    busy_n = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy_o) busy_n++;
      if (done_o) seen = 1;
      if (hold && !done_o) begin
        start_i = 1'b1;
        op_i = muldiv_e'($urandom_range(0, 7));
        a_i = $urandom; b_i = $urandom;
      end else begin
        start_i = 1'b0;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done_o in 40 cycles expected done_o");
    end
  endtask

  task automatic run_op(input muldiv_e op, input logic [31:0] a, input logic [31:0] b, input bit hold);
    int bn;
    issue(op, a, b, 1);
    wait_done(hold, bn);
    chk("busy_cycles", bn, is_special(op, a, b) ? 0 : 32);
  endtask

  task automatic rand_operands(output muldiv_e op, output logic [31:0] a, output logic [31:0] b);
    int sel;
    op = muldiv_e'($urandom_range(0, 7));
    a = $urandom; b = $urandom;
    sel = $urandom_range(0, 15);
    if (sel == 0) b = 0;
    else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
    else if (sel < 5) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
    else if (sel == 5) b = -$urandom_range(1, 20);
  endtask

  initial begin
    int      bn;
    muldiv_e op;
    logic [31:0] a, b;

    rst = 1'b1; start_i = 0; flush_i = 0; op_i = MD_MUL; a_i = 0; b_i = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_result", result_o, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy_o, 0);

    run_op(MD_MUL, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(MD_MULH,   32'h8000_0000, 32'h8000_0000, 0);
    run_op(MD_MULHSU, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(MD_MULHU,  32'h8000_0000, 32'h8000_0000, 0);
    run_op(MD_DIV,  -32'sd7, 32'd2, 0);
    run_op(MD_REM,  -32'sd7, 32'd2, 0);
    run_op(MD_DIVU, 32'd100, 32'd7, 0);
    run_op(MD_REMU, 32'd100, 32'd7, 0);
    run_op(MD_DIVU, 32'd5, 32'd0, 0);
    run_op(MD_REM,  32'd5, 32'd0, 0);
    run_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Flush at iteration 10: no done, result unchanged.
    issue(MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    repeat (10) begin @(negedge clk); start_i = 0; end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_busy", busy_o, 0);
    chk("flush_done", done_o, 0);
    chk("flush_result_kept", result_o, last_res);
    bn = 0;
    repeat (40) begin @(negedge clk); if (done_o || busy_o) bn++; end
    chk("flush_quiet", bn, 0);

    // Start held high throughout BUSY with changing operands is ignored.
    run_op(MD_MUL, 32'hDEAD_BEEF, 32'h0000_1235, 1);

    // Back-to-back: a start in the done cycle is accepted.
    run_op(MD_DIV, 32'hFFFF_F000, 32'd9, 0);
    run_op(MD_REMU, 32'hFFFF_FFFF, 32'd10, 0);
    run_op(MD_DIVU, 32'd42, 32'd0, 0);
    run_op(MD_MULH, -32'sd5, 32'd3, 0);

    // Flush beats a start presented in the done cycle.
    issue(MD_MUL, 32'd9, 32'd9, 1);
    wait_done(0, bn);
    issue(MD_DIVU, 32'd77, 32'd7, 0);
    flush_i = 1'b1;
    @(negedge clk);
    start_i = 0; flush_i = 0;
    chk("flush_vs_start_busy", busy_o, 0);
    chk("flush_vs_start_done", done_o, 0);

    // Asynchronous reset at iteration 20.
    issue(MD_REM, 32'h7654_3210, 32'd1234, 0);
    repeat (20) begin @(negedge clk); start_i = 0; end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy_o, 0);
    chk("async_rst_done", done_o, 0);
    chk("async_rst_result", result_o, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(MD_MUL, 32'd3, 32'd4, 0);

    // Random operations, some chained back-to-back, some with idle gaps.
    for (int n = 0; n < 60; n++) begin
      rand_operands(op, a, b);
      run_op(op, a, b, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
